pit_table: RTL and testbench
============================

# pit_table

Pending Interest Table for the NDN router: the responder on the FIB↔PIT data-return handshake and the origin of the PIT→FIB interest-forwarding request. Records outstanding interests (prefix + length) and forwards each new one to the FIB. Accepts or rejects data prefixes offered by the FIB and, on acceptance, receives the fixed-size data payload byte-by-byte and streams it to the downstream interface.

## Interface
- ENTRIES, 16, table depth (power of 2)
- PREFIX_W, 64, prefix width
- LEN_W, 6, prefix-length width
- DATA_BYTES, 1024, payload bytes per accepted data packet
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- int_valid  in  1  interest offered by interface
- int_prefix  in  PREFIX_W  interest prefix
- int_len  in  LEN_W  interest prefix length
- int_ready  out  1  interest accepted this cycle when high with int_valid
- pit_in_prefix  out  PREFIX_W  prefix forwarded to FIB
- pit_in_len  out  LEN_W  length forwarded to FIB
- fib_out_bit  out  1  one-cycle pulse: forward request to FIB
- fib_prefix  in  PREFIX_W  data prefix offered by FIB
- fib_len  in  LEN_W  data prefix length offered by FIB
- prefix_ready  in  1  FIB offers fib_prefix/fib_len
- fib_data  in  8  payload byte from FIB
- rejected  out  1  one-cycle pulse: no matching interest
- start_send_to_pit  out  1  one-cycle pulse: match, send payload
- data_out  out  8  payload byte to interface
- data_valid  out  1  data_out valid
- data_last  out  1  with final payload byte
- occupancy  out  $clog2(ENTRIES)+1  valid entries

## Operation
- Entry = {valid, prefix, len}; match = valid && prefix==P && len==L (exact).
- States: IDLE, MATCH_INT, MATCH_DATA, RESPOND, RECEIVE.
- IDLE: prefix_ready has priority → latch fib_prefix/fib_len, go MATCH_DATA. Else int_valid && int_ready → latch interest, go MATCH_INT.
- int_ready = (state==IDLE) && !prefix_ready && (occupancy < ENTRIES).
- MATCH_INT: hit → aggregate (no write, no fib_out_bit). Miss → write lowest-index free slot, occupancy+1, pulse fib_out_bit, drive pit_in_prefix/pit_in_len (held until next forward). → IDLE.
- MATCH_DATA: register match result and matching index (lowest on multiple hits) → RESPOND.
- RESPOND: miss → pulse rejected, → IDLE. Hit → pulse start_send_to_pit, clear entry, occupancy−1, reset byte counter, → RECEIVE.
- RECEIVE: sample fib_data every cycle, counter 0..DATA_BYTES−1; at DATA_BYTES−1 → IDLE. prefix_ready and int_valid ignored (int_ready low).
- Reset: all entries invalid; all outputs 0; state IDLE. Reset mid-RECEIVE aborts stream; data_last not produced.

## Timing
- Data offer: prefix_ready sampled at cycle T → rejected/start_send_to_pit high during T+2 only.
- Payload: bytes sampled T+3 … T+2+DATA_BYTES; each appears on data_out with data_valid one cycle after sampling; data_last with the byte sampled at T+2+DATA_BYTES. Earliest next prefix_ready sample T+3+DATA_BYTES.
- Interest: accepted at T → table write, occupancy update and fib_out_bit at T+2 (miss). Next int_ready at T+2.
- All outputs registered; no combinational in→out path except int_ready.
- Full table: int_ready low; data offers still served, freeing an entry.

## Structure
- Package pit_pkg: PREFIX_W, LEN_W defaults, state enum, entry typedef.
- Sub-module pit_cam: entry storage, parallel match vector, first-free and first-hit priority encoders, write/clear ports.

## Test plan
- Reset, insert prefix 0xA5A5_0000_0000_0001 len 16 → fib_out_bit one cycle at T+2 with same prefix/len, occupancy 1.
- Insert same interest again → no fib_out_bit, occupancy stays 1.
- prefix_ready with unknown prefix 0x1234 len 8 → rejected at T+2, no data_valid, occupancy unchanged.
- prefix_ready matching first entry, fib_data = counter mod 256 → start_send_to_pit at T+2, 1024 data_valid beats 0x00..0xFF repeating, data_last on beat 1024, occupancy 0.
- Fill 16 entries → int_ready low; one accepted data offer → int_ready high again; prefix_ready and int_valid same cycle → data offer served first.
- Assert rst low at payload byte 500 → data_valid 0 immediately, occupancy 0, no data_last, later offer of old prefix rejected.

Source files
------------

// File: rtl/pit_pkg.sv
// Shared widths, controller state encoding and entry layout for the pending
// interest table.
package pit_pkg;
    localparam int PIT_PREFIX_W = 64;
    localparam int PIT_LEN_W    = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MATCH_INT,
        S_MATCH_DATA,
        S_RESPOND,
        S_RECEIVE
    } state_t;

    typedef struct packed {
        logic                    valid;
        logic [PIT_PREFIX_W-1:0] prefix;
        logic [PIT_LEN_W-1:0]    len;
    } entry_t;
endpackage

// File: rtl/pit_cam.sv
// Entry storage with exact-match lookup on one key, lowest-index hit and
// lowest-index free slot encoders, one write port and one clear port.
module pit_cam #(
    parameter int ENTRIES  = 16,
    parameter int PREFIX_W = 64,
    parameter int LEN_W    = 6,
    parameter int IDX_W    = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PREFIX_W-1:0] key_prefix,
    input  logic [LEN_W-1:0]    key_len,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [PREFIX_W-1:0] wr_prefix,
    input  logic [LEN_W-1:0]    wr_len,
    input  logic                clr_en,
    input  logic [IDX_W-1:0]    clr_idx,
    output logic                hit,
    output logic [IDX_W-1:0]    hit_idx,
    output logic                free_any,
    output logic [IDX_W-1:0]    free_idx
);
    logic [ENTRIES-1:0]               vld_q, vld_d;
    logic [ENTRIES-1:0][PREFIX_W-1:0] pfx_q, pfx_d;
    logic [ENTRIES-1:0][LEN_W-1:0]    len_q, len_d;
    logic [ENTRIES-1:0]               match;

    always_comb begin
        match = '0;
        for (int i = 0; i < ENTRIES; i++)
            match[i] = vld_q[i] && (pfx_q[i] == key_prefix) && (len_q[i] == key_len);
    end

    // Walk high to low so the lowest matching / free index wins.
    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i])  hit_idx  = IDX_W'(i);
            if (!vld_q[i]) free_idx = IDX_W'(i);
        end
        hit      = |match;
        free_any = ~&vld_q;
    end

    always_comb begin
        vld_d = vld_q;
        pfx_d = pfx_q;
        len_d = len_q;
        if (wr_en) begin
            vld_d[wr_idx] = 1'b1;
            pfx_d[wr_idx] = wr_prefix;
            len_d[wr_idx] = wr_len;
        end
        if (clr_en)
            vld_d[clr_idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            pfx_q <= '0;
            len_q <= '0;
        end else begin
            vld_q <= vld_d;
            pfx_q <= pfx_d;
            len_q <= len_d;
        end
    end
endmodule

// File: rtl/pit_table.sv
// Pending interest table: records interests, forwards new ones to the FIB,
// and accepts/rejects FIB data offers, streaming accepted payloads downstream.
module pit_table
    import pit_pkg::*;
#(
    parameter int ENTRIES    = 16,
    parameter int PREFIX_W   = PIT_PREFIX_W,
    parameter int LEN_W      = PIT_LEN_W,
    parameter int DATA_BYTES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       int_valid,
    input  logic [PREFIX_W-1:0]        int_prefix,
    input  logic [LEN_W-1:0]           int_len,
    output logic                       int_ready,
    output logic [PREFIX_W-1:0]        pit_in_prefix,
    output logic [LEN_W-1:0]           pit_in_len,
    output logic                       fib_out_bit,
    input  logic [PREFIX_W-1:0]        fib_prefix,
    input  logic [LEN_W-1:0]           fib_len,
    input  logic                       prefix_ready,
    input  logic [7:0]                 fib_data,
    output logic                       rejected,
    output logic                       start_send_to_pit,
    output logic [7:0]                 data_out,
    output logic                       data_valid,
    output logic                       data_last,
    output logic [$clog2(ENTRIES):0]   occupancy
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int OCC_W = IDX_W + 1;
    localparam int CNT_W = $clog2(DATA_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BYTES - 1);

    state_t              state_q, state_d;
    logic [PREFIX_W-1:0] key_pfx_q, key_pfx_d;
    logic [LEN_W-1:0]    key_len_q, key_len_d;
    logic                hit_q, hit_d;
    logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [PREFIX_W-1:0] pit_pfx_q, pit_pfx_d;
    logic [LEN_W-1:0]    pit_len_q, pit_len_d;
    logic                fwd_q, fwd_d;
    logic                rej_q, rej_d;
    logic                start_q, start_d;
    logic [7:0]          dout_q, dout_d;
    logic                dvld_q, dvld_d;
    logic                dlast_q, dlast_d;

    logic                cam_hit, cam_free_any, wr_en, clr_en;
    logic [IDX_W-1:0]    cam_hit_idx, cam_free_idx;

    pit_cam #(
        .ENTRIES  (ENTRIES),
        .PREFIX_W (PREFIX_W),
        .LEN_W    (LEN_W),
        .IDX_W    (IDX_W)
    ) u_cam (
        .clk        (clk),
        .rst        (rst),
        .key_prefix (key_pfx_q),
        .key_len    (key_len_q),
        .wr_en      (wr_en),
        .wr_idx     (cam_free_idx),
        .wr_prefix  (key_pfx_q),
        .wr_len     (key_len_q),
        .clr_en     (clr_en),
        .clr_idx    (hit_idx_q),
        .hit        (cam_hit),
        .hit_idx    (cam_hit_idx),
        .free_any   (cam_free_any),
        .free_idx   (cam_free_idx)
    );

    // Data offers take precedence, so an interest is only taken when no offer is pending.
    assign int_ready = (state_q == S_IDLE) && !prefix_ready && (occ_q < OCC_W'(ENTRIES));

    always_comb begin
        state_d   = state_q;
        key_pfx_d = key_pfx_q;
        key_len_d = key_len_q;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;
        cnt_d     = cnt_q;
        occ_d     = occ_q;
        pit_pfx_d = pit_pfx_q;
        pit_len_d = pit_len_q;
        fwd_d     = 1'b0;
        rej_d     = 1'b0;
        start_d   = 1'b0;
        dout_d    = dout_q;
        dvld_d    = 1'b0;
        dlast_d   = 1'b0;
        wr_en     = 1'b0;
        clr_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (prefix_ready) begin
                    key_pfx_d = fib_prefix;
                    key_len_d = fib_len;
                    state_d   = S_MATCH_DATA;
                end else if (int_valid && int_ready) begin
                    key_pfx_d = int_prefix;
                    key_len_d = int_len;
                    state_d   = S_MATCH_INT;
                end
            end
            S_MATCH_INT: begin
                // A hit aggregates into the existing entry: nothing to write or forward.
                if (!cam_hit && cam_free_any) begin
                    wr_en     = 1'b1;
                    occ_d     = occ_q + 1'b1;
                    fwd_d     = 1'b1;
                    pit_pfx_d = key_pfx_q;
                    pit_len_d = key_len_q;
                end
                state_d = S_IDLE;
            end
            S_MATCH_DATA: begin
                hit_d     = cam_hit;
                hit_idx_d = cam_hit_idx;
                rej_d     = !cam_hit;
                start_d   = cam_hit;
                state_d   = S_RESPOND;
            end
            S_RESPOND: begin
                if (hit_q) begin
                    clr_en  = 1'b1;
                    occ_d   = occ_q - 1'b1;
                    cnt_d   = '0;
                    state_d = S_RECEIVE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RECEIVE: begin
                dout_d  = fib_data;
                dvld_d  = 1'b1;
                dlast_d = (cnt_q == CNT_LAST);
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            key_pfx_q <= '0;
            key_len_q <= '0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            cnt_q     <= '0;
            occ_q     <= '0;
            pit_pfx_q <= '0;
            pit_len_q <= '0;
            fwd_q     <= 1'b0;
            rej_q     <= 1'b0;
            start_q   <= 1'b0;
            dout_q    <= '0;
            dvld_q    <= 1'b0;
            dlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_pfx_q <= key_pfx_d;
            key_len_q <= key_len_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
            cnt_q     <= cnt_d;
            occ_q     <= occ_d;
            pit_pfx_q <= pit_pfx_d;
            pit_len_q <= pit_len_d;
            fwd_q     <= fwd_d;
            rej_q     <= rej_d;
            start_q   <= start_d;
            dout_q    <= dout_d;
            dvld_q    <= dvld_d;
            dlast_q   <= dlast_d;
        end
    end

    assign pit_in_prefix     = pit_pfx_q;
    assign pit_in_len        = pit_len_q;
    assign fib_out_bit       = fwd_q;
    assign rejected          = rej_q;
    assign start_send_to_pit = start_q;
    assign data_out          = dout_q;
    assign data_valid        = dvld_q;
    assign data_last         = dlast_q;
    assign occupancy         = occ_q;
endmodule

// File: tb/tb_pit_table.sv
// Directed bench for pit_table: interest insert/aggregate, reject, payload
// stream, full table, offer priority and reset mid-stream.
module tb_pit_table;
    localparam int DB = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        int_valid = 1'b0;
    logic [63:0] int_prefix = '0;
    logic [5:0]  int_len = '0;
    logic        int_ready;
    logic [63:0] pit_in_prefix;
    logic [5:0]  pit_in_len;
    logic        fib_out_bit;
    logic [63:0] fib_prefix = '0;
    logic [5:0]  fib_len = '0;
    logic        prefix_ready = 1'b0;
    logic [7:0]  fib_data = '0;
    logic        rejected, start_send_to_pit;
    logic [7:0]  data_out;
    logic        data_valid, data_last;
    logic [4:0]  occupancy;

    int errors = 0;
    int checks = 0;

    pit_table #(.ENTRIES(16), .PREFIX_W(64), .LEN_W(6), .DATA_BYTES(DB)) dut (
        .clk               (clk),
        .rst               (rst),
        .int_valid         (int_valid),
        .int_prefix        (int_prefix),
        .int_len           (int_len),
        .int_ready         (int_ready),
        .pit_in_prefix     (pit_in_prefix),
        .pit_in_len        (pit_in_len),
        .fib_out_bit       (fib_out_bit),
        .fib_prefix        (fib_prefix),
        .fib_len           (fib_len),
        .prefix_ready      (prefix_ready),
        .fib_data          (fib_data),
        .rejected          (rejected),
        .start_send_to_pit (start_send_to_pit),
        .data_out          (data_out),
        .data_valid        (data_valid),
        .data_last         (data_last),
        .occupancy         (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Interest accepted at the first edge; forward visible two cycles later.
    task automatic send_int(input logic [63:0] p, input logic [5:0] l, input bit fwd,
                            input logic [4:0] occ_after);
        @(negedge clk);
        int_valid = 1'b1; int_prefix = p; int_len = l;
        #1 chk("int_ready_accept", int_ready, 1);
        @(negedge clk);
        int_valid = 1'b0;
        chk("fwd_early", fib_out_bit, 0);
        chk("int_ready_busy", int_ready, 0);
        @(negedge clk);
        chk("fwd", fib_out_bit, fwd);
        if (fwd) begin
            chk("pit_in_prefix", pit_in_prefix, p);
            chk("pit_in_len", pit_in_len, l);
        end
        chk("occ_int", occupancy, occ_after);
        chk("int_ready_t2", int_ready, occ_after < 5'd16);
    endtask

    // Data offer; on a hit the payload is byte k = k mod 256. abort_at >= 0 resets
    // the DUT just before that payload byte is presented.
    task automatic offer(input logic [63:0] p, input logic [5:0] l, input bit hit,
                         input bit with_int, input int abort_at, input logic [4:0] occ_after);
        int  bad;
        bit  aborted;
        bad = 0;
        aborted = 1'b0;
        @(negedge clk);
        prefix_ready = 1'b1; fib_prefix = p; fib_len = l;
        int_valid = with_int; int_prefix = 64'h999; int_len = 6'd8;
        #1 chk("int_ready_offer", int_ready, 0);
        @(negedge clk);
        prefix_ready = 1'b0; int_valid = 1'b0;
        chk("resp_early", {rejected, start_send_to_pit}, 0);
        @(negedge clk);
        chk("rejected", rejected, !hit);
        chk("start_send", start_send_to_pit, hit);
        chk("no_fwd_on_offer", fib_out_bit, 0);
        if (hit) begin
            for (int k = 0; k <= DB; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    if (data_valid) bad++;
                end else begin
                    if (!data_valid || data_out != 8'(k - 1)) bad++;
                    if (data_last != (k == DB)) bad++;
                end
                if (k == 11) chk("int_ready_rx", int_ready, 0);
                if (k == abort_at) begin
                    rst = 1'b0;
                    #1;
                    chk("abort_valid", data_valid, 0);
                    chk("abort_last", data_last, 0);
                    chk("abort_occ", occupancy, 0);
                    @(negedge clk);
                    rst = 1'b1;
                    aborted = 1'b1;
                    break;
                end
                fib_data = 8'(k);
            end
            chk("beats", bad, 0);
            if (!aborted) begin
                @(negedge clk);
                chk("valid_after_stream", {data_valid, data_last}, 0);
            end
        end else begin
            @(negedge clk);
            chk("no_data_on_reject", data_valid, 0);
        end
        chk("occ_offer", occupancy, occ_after);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_occ", occupancy, 0);
        chk("rst_outs", {fib_out_bit, rejected, start_send_to_pit, data_valid, data_last}, 0);
        chk("rst_int_ready", int_ready, 1);
        rst = 1'b1;

        send_int(64'hA5A5_0000_0000_0001, 6'd16, 1'b1, 5'd1);
        send_int(64'hA5A5_0000_0000_0001, 6'd16, 1'b0, 5'd1);
        chk("pit_prefix_held", pit_in_prefix, 64'hA5A5_0000_0000_0001);
        offer(64'h1234, 6'd8, 1'b0, 1'b0, -1, 5'd1);
        // Same prefix, different length: exact match required.
        offer(64'hA5A5_0000_0000_0001, 6'd8, 1'b0, 1'b0, -1, 5'd1);
        offer(64'hA5A5_0000_0000_0001, 6'd16, 1'b1, 1'b0, -1, 5'd0);

        for (int i = 0; i < 16; i++)
            send_int(64'h100 + 64'(i), 6'd8, 1'b1, 5'(i + 1));
        @(negedge clk);
        int_valid = 1'b1; int_prefix = 64'h777; int_len = 6'd8;
        #1 chk("int_ready_full", int_ready, 0);
        @(negedge clk);
        int_valid = 1'b0;
        chk("occ_full", occupancy, 16);

        offer(64'h103, 6'd8, 1'b1, 1'b0, -1, 5'd15);
        #1 chk("int_ready_after_free", int_ready, 1);
        offer(64'h105, 6'd8, 1'b1, 1'b1, -1, 5'd14);

        offer(64'h100, 6'd8, 1'b1, 1'b0, 500, 5'd0);
        offer(64'h100, 6'd8, 1'b0, 1'b0, -1, 5'd0);
        send_int(64'h42, 6'd4, 1'b1, 5'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
